// File: rtl/nios2_oci_dct_pkg.sv
// Shared constants and FSM state encoding for the OCI debug-trace packer.
// No logic lives here.
// Imported by the packer top.
package nios2_oci_dct_pkg;

    localparam int SYM_W = 2;             // bits per trace symbol
    localparam int DEPTH = 15;            // symbols per frame
    localparam int BUF_W = SYM_W * DEPTH; // packed frame width (30)
    localparam int CNT_W = 4;             // frame occupancy width, holds DEPTH

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,  // accepting symbols
        ST_EMIT  = 2'd1,  // full frame presented
        ST_DRAIN = 2'd2,  // partial frame presented on end of test
        ST_DONE  = 2'd3   // terminal until reset
    } dct_state_t;

endpackage

// File: rtl/nios2_oci_dct_packer.sv
// Packs 2-bit trace symbols into a 30-bit dct_buffer frame with occupancy count.
// Latency: frame presented (dct_valid) on the same edge that accepts its last symbol.
// Backpressure: sym_ready drops while a frame waits for dct_ready; no symbol is dropped.
module nios2_oci_dct_packer
    import nios2_oci_dct_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sym_valid,
    input  logic [SYM_W-1:0] sym,
    output logic             sym_ready,
    input  logic             end_req,
    output logic [BUF_W-1:0] dct_buffer,
    output logic [CNT_W-1:0] dct_count,
    output logic             dct_valid,
    input  logic             dct_ready,
    output logic             test_ending,
    output logic             test_has_ended
);

    dct_state_t       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             end_pend_q, end_pend_d;
    logic             ending_q, ending_d;
    logic             ended_q, ended_d;
    logic             sym_rdy_q, sym_rdy_d;
    logic             dct_vld_q, dct_vld_d;

    logic             accept;
    logic             handshake;

    // Handshakes are judged against the registered outputs the peers actually see.
    assign accept    = sym_valid && sym_rdy_q;
    assign handshake = dct_vld_q && dct_ready;

    // Next-state logic: accumulator update, FSM transitions and output flags.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        end_pend_d = end_pend_q;
        ending_d   = ending_q;
        ended_d    = ended_q;

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    // Write the symbol at the slot indexed by the current count.
                    for (int i = 0; i < DEPTH; i++) begin
                        if (CNT_W'(i) == cnt_q) begin
                            buf_d[i*SYM_W +: SYM_W] = sym;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (end_req) begin
                    // A symbol accepted alongside end_req belongs to the last frame.
                    if (cnt_d == CNT_W'(DEPTH)) begin
                        state_d    = ST_EMIT;
                        end_pend_d = 1'b1;
                        ending_d   = 1'b1;
                    end else if (cnt_d != '0) begin
                        state_d  = ST_DRAIN;
                        ending_d = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (cnt_d == CNT_W'(DEPTH)) begin
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (end_req && !end_pend_q) begin
                    end_pend_d = 1'b1;
                    ending_d   = 1'b1;
                end
                if (handshake) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    // An end request arriving on the handshake edge still ends the test.
                    state_d = (end_pend_q || end_req) ? ST_DONE : ST_FILL;
                end
            end

            ST_DRAIN: begin
                if (handshake) begin
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end

            default: begin
                // ST_DONE: terminal, end_req and symbols ignored.
            end
        endcase

        // Entering DONE retires the drain indication and raises the sticky flag together.
        if (state_d == ST_DONE) begin
            ending_d = 1'b0;
            ended_d  = 1'b1;
        end

        sym_rdy_d = (state_d == ST_FILL);
        dct_vld_d = (state_d == ST_EMIT) || (state_d == ST_DRAIN);
    end

    // State and registered outputs; reset discards any in-flight frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_FILL;
            buf_q      <= '0;
            cnt_q      <= '0;
            end_pend_q <= 1'b0;
            ending_q   <= 1'b0;
            ended_q    <= 1'b0;
            sym_rdy_q  <= 1'b0;
            dct_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            end_pend_q <= end_pend_d;
            ending_q   <= ending_d;
            ended_q    <= ended_d;
            sym_rdy_q  <= sym_rdy_d;
            dct_vld_q  <= dct_vld_d;
        end
    end

    assign sym_ready      = sym_rdy_q;
    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign dct_valid      = dct_vld_q;
    assign test_ending    = ending_q;
    assign test_has_ended = ended_q;

endmodule

// File: doc/nios2_oci_dct_packer.md
# nios2_oci_dct_packer

Producer side of the Nios II OCI debug-trace (DCT) buffer interface. Accepts a stream of 2-bit trace symbols from the OCI trace logic and packs them into the 30-bit `dct_buffer` word with its `dct_count`. It presents each full or drained frame to the downstream trace consumer with a valid/ready handshake and drives the `test_ending` / `test_has_ended` end-of-test pair.

## Interface
- `SYM_W`, 2: bits per trace symbol
- `DEPTH`, 15: symbols per frame; buffer width = `SYM_W*DEPTH` = 30
- `CNT_W`, 4: width of `dct_count`; must hold `DEPTH`

- `clk`  in  1  single clock
- `reset_n`  in  1  asynchronous, active-low reset
- `sym_valid`  in  1  trace symbol offered
- `sym`  in  `SYM_W`  trace symbol
- `sym_ready`  out  1  symbol accepted on the edge where `sym_valid && sym_ready`
- `end_req`  in  1  request drain and end of test; level, sampled each cycle
- `dct_buffer`  out  30  packed symbols; symbol i at bits [2i+1:2i]; unused upper bits 0
- `dct_count`  out  `CNT_W`  number of valid symbols in `dct_buffer`
- `dct_valid`  out  1  frame presented
- `dct_ready`  in  1  consumer takes frame on the edge where `dct_valid && dct_ready`
- `test_ending`  out  1  drain in progress
- `test_has_ended`  out  1  sticky end flag

## Operation
- States: FILL, EMIT, DRAIN, DONE. Reset to FILL.
- All outputs are registered. On reset, all outputs are 0 and the accumulator and end_pending are cleared.
- `dct_buffer` and `dct_count` always show the live accumulator. `dct_valid` qualifies them.
- FILL: `sym_ready`=1. An accepted symbol is written at index `dct_count`, then `dct_count`+1.
  - If the accept brings the count to `DEPTH`, go to EMIT.
  - `end_req` seen in FILL, including in the same cycle as an accept: set `test_ending`. The symbol accepted in that cycle is included. Then:
    - count (after the accept) = `DEPTH` → EMIT with end_pending set
    - count in 1..14 → DRAIN
    - count 0 → DONE
- EMIT: `dct_valid`=1, `sym_ready`=0. Buffer and count are held stable until the handshake.
  - `end_req` seen in EMIT latches end_pending and sets `test_ending`.
  - On handshake: clear the accumulator (buffer=0, count=0). Go to DONE if end_pending, else to FILL.
- DRAIN: like EMIT, with a partial count. On handshake, clear the accumulator and go to DONE.
- DONE: `sym_ready`=0, `dct_valid`=0, `test_ending`=0, `test_has_ended`=1. Terminal until reset. `end_req` is ignored.
- `end_req` is ignored after the first time it is seen. No symbols are dropped; backpressure only.

## Timing
- An accept at edge N that fills the frame gives `dct_valid`=1 and `sym_ready`=0 from edge N onward.
- A handshake at edge M gives `dct_valid`=0, `dct_count`=0 and `sym_ready`=1 after M. There is one bubble cycle per frame, so throughput is 15 symbols per 16 cycles at full rate.
- `test_ending` rises on the edge after `end_req` is sampled. It falls on the same edge that `test_has_ended` rises.
- Async reset clears state immediately, even mid-EMIT/DRAIN. Any in-flight frame is lost.

## Structure
- Package `nios2_oci_dct_pkg` holds:
  - constants `SYM_W`, `DEPTH`, `BUF_W`, `CNT_W`
  - the state enum `dct_state_t`
- Single module with no submodule. The accumulator, FSM and end_pending flag are all local.

## Test plan
- Reset: hold `reset_n`=0 → all outputs 0, state FILL. Release → `sym_ready`=1 on the next cycle.
- Full frame: 15 symbols cycling 0,1,2,3,0…, `dct_ready`=1 → one frame with `dct_buffer`=0x24E4E4E4, `dct_count`=15, `dct_valid` high for 1 cycle, then `sym_ready`=1.
- Backpressure: full frame with `dct_ready`=0 for 5 cycles → buffer and count stable, `sym_ready`=0 throughout. A pending 16th symbol is accepted on the cycle after the handshake, giving `dct_count`=1.
- Partial drain: symbols 3,3,1 then `end_req` → `test_ending`=1, DRAIN frame with `dct_buffer`=0x1F and `dct_count`=3. After the handshake, `test_has_ended`=1 and `test_ending`=0.
- End with full frame: `end_req` in the same cycle as the 15th symbol accept → one full frame of count 15, then DONE. No extra partial frame and no empty frame.
- Reset mid-EMIT: assert `reset_n`=0 while `dct_valid`=1 → `dct_valid`, `dct_count` and `dct_buffer` go to 0 asynchronously. After release, the next frame starts at count 0.
